vga_scan_generator: RTL
=======================

// Module: vga_scan_generator
// PURPOSE
// - Pixel-scan source for the whole drawing chain. Counts the VGA raster and drives pixelX/pixelY into every
//   object and drawing block. Takes back the merged 8-bit RGB332 colour and emits aligned hSync/vSync/blankN
//   plus 8-bit R/G/B to the VGA DAC.
// - Also emits a one-cycle startOfFrame pulse so game logic updates positions during vertical blanking.
// PARAMETERS
// - H_ACTIVE 640 visible pixels per line;  H_FRONT 16;  H_SYNC 96;  H_BACK 48 (H_TOTAL = 800)
// - V_ACTIVE 480 visible lines;  V_FRONT 10;  V_SYNC 2;  V_BACK 33 (V_TOTAL = 525)
// - SYNC_ACTIVE 0: asserted level of hSync/vSync (0 = active-low).
// - PIPE_DELAY 2: clk cycles from a pixelX/pixelY value to its RGBIn arriving back. Legal range 0..7.
// PORTS
// - clk          in   1    pixel clock, one pixel per cycle (25 MHz)
// - resetN       in   1    asynchronous active-low reset
// - RGBIn        in   8    merged RGB332 colour for the pixel issued PIPE_DELAY cycles earlier
// - pixelX       out  11   signed, current horizontal count, 0..H_TOTAL-1
// - pixelY       out  11   signed, current vertical count, 0..V_TOTAL-1
// - startOfFrame out  1    one-cycle pulse at hCount==0, vCount==V_ACTIVE
// - hSync        out  1    horizontal sync, aligned with colour outputs
// - vSync        out  1    vertical sync, aligned with colour outputs
// - blankN       out  1    1 = visible pixel on the colour outputs
// - red, green, blue out 8 each   DAC colour
// BEHAVIOUR
// - Reset values: hCount = vCount = 0, pixelX = pixelY = 0, startOfFrame = 0, blankN = 0, R/G/B = 0.
//   hSync and vSync sit at the deasserted level (!SYNC_ACTIVE). All delay-line stages are cleared to blank,
//   deasserted. Reset mid-line or mid-frame restarts the raster at (0,0) on the first cycle after release.
// - Counters: hCount increments every clk and wraps H_TOTAL-1 -> 0. vCount increments on the hCount wrap
//   and wraps V_TOTAL-1 -> 0 on the cycle both counters are at their maximum.
// - pixelX/pixelY are registered copies of hCount/vCount. They are not clamped in blanking: objects may
//   assert draw there, and that colour is discarded.
// - Raw timing, computed from the counters:
//   - active = hCount < H_ACTIVE && vCount < V_ACTIVE
//   - hs = hCount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]
//   - vs = vCount in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]
// - Alignment: active/hs/vs pass through a PIPE_DELAY-stage delay line. One final register stage then drives
//   blankN, hSync, vSync, red, green and blue together. Total latency from pixelX/pixelY to the matching DAC
//   outputs is PIPE_DELAY+1 cycles.
// - Colour, in the final register stage:
//   - delayed active = 0 -> R/G/B = 0.
//   - delayed active = 1 and RGBIn == COLOR_TRANSPARENT -> R/G/B = 0 (black background).
//   - otherwise, expand by bit replication:
//     red = {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]}
//     green = {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]}
//     blue = {4{RGBIn[1:0]}}
// - startOfFrame is registered. It is high for exactly the one cycle in which pixelX==0 and pixelY==V_ACTIVE,
//   so there is one pulse per V_TOTAL*H_TOTAL cycles. It is not delayed by PIPE_DELAY.
// - Simultaneous wrap (last pixel of the frame) updates both counters in the same cycle. There is no
//   intermediate (0, V_TOTAL) state.
// STRUCTURE
// - Package defines: add the H_/V_ timing localparams, a vga_timing_t struct {active, hs, vs}, and a
//   function rgb332_expand returning the 24-bit colour. COLOR_TRANSPARENT stays where it is.
// - Sub-module pixel_delay_line #(WIDTH, DEPTH): async-reset shift register with a reset value input.
//   DEPTH 0 is a pass-through. It is instantiated once for vga_timing_t.
// TESTING
// - Release reset: pixelX steps 0,1,2.. each clk; pixelX==799 is followed by 0 with pixelY 0->1.
//   Exactly 420000 clks separate consecutive startOfFrame pulses.
// - hSync: for pixelX in 656..751 it is asserted (0), with the 96-cycle low pulse seen at the output
//   PIPE_DELAY+1 clks later. vSync: low for exactly 2 lines (1600 clks) starting at pixelY 490.
// - Colour at (10,10):
//   - RGBIn=8'hE0 -> red=8'hFF, green=0, blue=0, blankN=1, PIPE_DELAY+1 clks after pixelX==10.
//   - RGBIn=8'h1F -> green=8'hFF, blue=8'hFF.
// - Blanking: RGBIn=8'hFF driven constantly -> R/G/B=0 and blankN=0 whenever the delayed pixelX>=640 or
//   pixelY>=480. RGBIn=COLOR_TRANSPARENT in the visible area -> R/G/B=0, blankN=1.
// - Reset mid-frame at pixel (300,200): all outputs return to reset values asynchronously. After release,
//   pixelX/pixelY restart at 0,0 and no stale colour or sync emerges from the delay line.
// - Sweep PIPE_DELAY over 0 and 2: blankN rises exactly PIPE_DELAY+1 clks after pixelX==0 on line 0.

Source files
------------

// File: rtl/vga_scan_generator_pkg.sv
// rtl/vga_scan_generator_pkg.sv - VGA 640x480 raster timing constants, timing struct and RGB332 expansion
package vga_scan_generator_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [7:0] COLOR_TRANSPARENT = 8'hFF;

  // hs/vs are held active-high here; polarity is applied only at the output register
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_timing_t;

  function automatic logic [23:0] rgb332_expand(input logic [7:0] rgb);
    return {rgb[7:5], rgb[7:5], rgb[7:6],
            rgb[4:2], rgb[4:2], rgb[4:3],
            {4{rgb[1:0]}}};
  endfunction

endpackage

// File: rtl/vga_scan_generator_pixel_delay_line.sv
// rtl/vga_scan_generator_pixel_delay_line.sv - async-reset shift register aligning timing with returning colour
module pixel_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] rstValue,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk, resetN, rstValue};
      assign dataOut = dataIn;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= rstValue;
        end else begin
          stages[0] <= dataIn;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dataOut = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA raster counter, pixel coordinate source and aligned sync/colour output stage
module vga_scan_generator #(
  parameter int   H_ACTIVE    = vga_scan_generator_pkg::H_ACTIVE,
  parameter int   H_FRONT     = vga_scan_generator_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_scan_generator_pkg::H_SYNC,
  parameter int   H_BACK      = vga_scan_generator_pkg::H_BACK,
  parameter int   V_ACTIVE    = vga_scan_generator_pkg::V_ACTIVE,
  parameter int   V_FRONT     = vga_scan_generator_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_scan_generator_pkg::V_SYNC,
  parameter int   V_BACK      = vga_scan_generator_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_DELAY  = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [7:0]         RGBIn,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               startOfFrame,
  output logic               hSync,
  output logic               vSync,
  output logic               blankN,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue
);
  import vga_scan_generator_pkg::*;

  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [10:0] hCount;
  logic [10:0] vCount;
  vga_timing_t timingRaw;
  vga_timing_t timingQ;
  vga_timing_t timingDelayed;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hCount == H_LAST) begin
      hCount <= '0;
      vCount <= (vCount == V_LAST) ? 11'd0 : vCount + 11'd1;
    end else begin
      hCount <= hCount + 11'd1;
    end
  end

  always_comb begin
    timingRaw        = '0;
    timingRaw.active = (hCount < H_VIS) && (vCount < V_VIS);
    timingRaw.hs     = (hCount >= HS_FIRST) && (hCount <= HS_LAST);
    timingRaw.vs     = (vCount >= VS_FIRST) && (vCount <= VS_LAST);
  end

  // Timing is registered alongside pixelX/pixelY so both leave in the same cycle and reset to blank
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX       <= '0;
      pixelY       <= '0;
      startOfFrame <= 1'b0;
      timingQ      <= '0;
    end else begin
      pixelX       <= $signed(hCount);
      pixelY       <= $signed(vCount);
      startOfFrame <= (hCount == 11'd0) && (vCount == V_VIS);
      timingQ      <= timingRaw;
    end
  end

  pixel_delay_line #(
    .WIDTH($bits(vga_timing_t)),
    .DEPTH(PIPE_DELAY)
  ) u_timing_delay (
    .clk      (clk),
    .resetN   (resetN),
    .rstValue ('0),
    .dataIn   (timingQ),
    .dataOut  (timingDelayed)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blankN              <= 1'b0;
      hSync               <= !SYNC_ACTIVE;
      vSync               <= !SYNC_ACTIVE;
      {red, green, blue}  <= '0;
    end else begin
      blankN <= timingDelayed.active;
      hSync  <= timingDelayed.hs ? SYNC_ACTIVE : !SYNC_ACTIVE;
      vSync  <= timingDelayed.vs ? SYNC_ACTIVE : !SYNC_ACTIVE;
      if (timingDelayed.active && (RGBIn != COLOR_TRANSPARENT))
        {red, green, blue} <= rgb332_expand(RGBIn);
      else
        {red, green, blue} <= '0;
    end
  end

endmodule
